// File: rtl/nwc_pkg.sv
// Shared constants and enums for the NWC input loader.
// Bank select and loader state live here so all files agree.
package nwc_pkg;

  localparam int LOG_COEFFS = 12;
  localparam int COEFF_BITS = 30;
  localparam int FRAME_LEN  = 2 * (1 << LOG_COEFFS);
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = LOG_COEFFS + 1;

  localparam logic [3:0] WEN_ALL = 4'hF;

  typedef enum logic [1:0] {
    IN0_UP   = 2'd0,
    IN0_DOWN = 2'd1,
    IN1_UP   = 2'd2,
    IN1_DOWN = 2'd3
  } bank_e;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    FIRE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/nwc_input_loader_if.sv
// Stream, BRAM write and NWC-top control bundle.
// slave is the loader side; master is the feeder/NWC side.
interface nwc_input_loader_if;
  import nwc_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic              memory_writable;
  logic              start_ready;
  logic              start;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wen_in0_up;
  logic [3:0]        wen_in0_down;
  logic [3:0]        wen_in1_up;
  logic [3:0]        wen_in1_down;
  logic              busy;
  logic              err_range;
  logic              err_last;

  modport slave (
    input  s_data, s_valid, s_last,
    input  memory_writable, start_ready,
    output s_ready, start, waddr, wdata,
    output wen_in0_up, wen_in0_down,
    output wen_in1_up, wen_in1_down,
    output busy, err_range, err_last
  );

  modport master (
    output s_data, s_valid, s_last,
    output memory_writable, start_ready,
    input  s_ready, start, waddr, wdata,
    input  wen_in0_up, wen_in0_down,
    input  wen_in1_up, wen_in1_down,
    input  busy, err_range, err_last
  );

endinterface

// File: rtl/nwc_bank_decoder.sv
// Maps polynomial/half select bits to the four bank
// byte enables; at most one bank is enabled.
module nwc_bank_decoder
  import nwc_pkg::*;
(
  input  logic       en_i,
  input  logic       poly_i,
  input  logic       half_i,
  output logic [3:0] wen_in0_up_o,
  output logic [3:0] wen_in0_down_o,
  output logic [3:0] wen_in1_up_o,
  output logic [3:0] wen_in1_down_o
);

  bank_e bank;
  assign bank = bank_e'({poly_i, half_i});

  // one-hot fan-out of the full-word enable
  always_comb begin
    wen_in0_up_o   = '0;
    wen_in0_down_o = '0;
    wen_in1_up_o   = '0;
    wen_in1_down_o = '0;
    if (en_i) begin
      unique case (bank)
        IN0_UP:   wen_in0_up_o   = WEN_ALL;
        IN0_DOWN: wen_in0_down_o = WEN_ALL;
        IN1_UP:   wen_in1_up_o   = WEN_ALL;
        IN1_DOWN: wen_in1_down_o = WEN_ALL;
      endcase
    end
  end

endmodule

// File: rtl/nwc_input_loader.sv
// Loads two coefficient polynomials into the NWC input
// banks, then hands off to the NWC top with a start pulse.
module nwc_input_loader
  import nwc_pkg::*;
#(
  parameter int LOG_COEFFS_P = LOG_COEFFS,
  parameter int COEFF_BITS_P = COEFF_BITS
) (
  input logic clk,
  input logic rst_n,
  nwc_input_loader_if.slave bus
);

  localparam int CW = LOG_COEFFS_P + 1;
  localparam logic [CW-1:0] LAST_IDX = '1;

  ld_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_range_q, err_range_d;
  logic          err_last_q, err_last_d;
  logic          start_q;
  logic [CW-1:0] waddr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wen0u_q, wen0d_q;
  logic [3:0]    wen1u_q, wen1d_q;
  logic [3:0]    dec0u, dec0d, dec1u, dec1d;
  logic          ready;
  logic          xfer;
  logic          bad_bits;

  // reset gates ready so it is low while rst_n is held
  assign ready = rst_n && (state_q == LOAD)
              && bus.memory_writable;
  assign xfer  = bus.s_valid && ready;
  assign bad_bits = |bus.s_data[31:COEFF_BITS_P];

  nwc_bank_decoder u_dec (
    .en_i           (xfer),
    .poly_i         (count_q[CW-1]),
    .half_i         (count_q[0]),
    .wen_in0_up_o   (dec0u),
    .wen_in0_down_o (dec0d),
    .wen_in1_up_o   (dec1u),
    .wen_in1_down_o (dec1d)
  );

  // next state, frame counter and sticky error flags
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_range_d = err_range_q | (xfer & bad_bits);
    err_last_d  = err_last_q;
    case (state_q)
      LOAD: begin
        if (xfer) begin
          if (count_q == LAST_IDX) begin
            state_d = WAIT;
            count_d = '0;
            if (!bus.s_last) err_last_d = 1'b1;
          end else if (bus.s_last) begin
            count_d    = '0;
            err_last_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.start_ready) state_d = FIRE;
      end
      FIRE: begin
        state_d = LOAD;
        count_d = '0;
      end
      default: begin
        state_d = LOAD;
        count_d = '0;
      end
    endcase
  end

  // control state; start follows the FIRE cycle by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      count_q     <= '0;
      err_range_q <= 1'b0;
      err_last_q  <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_range_q <= err_range_d;
      err_last_q  <= err_last_d;
      start_q     <= (state_q == FIRE);
    end
  end

  // registered BRAM write port; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= '0;
      wdata_q <= '0;
      wen0u_q <= '0;
      wen0d_q <= '0;
      wen1u_q <= '0;
      wen1d_q <= '0;
    end else begin
      wen0u_q <= dec0u;
      wen0d_q <= dec0d;
      wen1u_q <= dec1u;
      wen1d_q <= dec1d;
      if (xfer) begin
        waddr_q <= {count_q[CW-2:1], 2'b00};
        wdata_q <= {{(32-COEFF_BITS_P){1'b0}},
                    bus.s_data[COEFF_BITS_P-1:0]};
      end
    end
  end

  assign bus.s_ready      = ready;
  assign bus.start        = start_q;
  assign bus.waddr        = waddr_q;
  assign bus.wdata        = wdata_q;
  assign bus.wen_in0_up   = wen0u_q;
  assign bus.wen_in0_down = wen0d_q;
  assign bus.wen_in1_up   = wen1u_q;
  assign bus.wen_in1_down = wen1d_q;
  assign bus.busy         = (state_q != LOAD)
                         || (count_q != '0);
  assign bus.err_range    = err_range_q;
  assign bus.err_last     = err_last_q;

endmodule
